// File: rtl/gpio_in_debounce.sv
// Memory-mapped push-button input port: 2-flop sync, per-pin debounce, W1C press latch, maskable IRQ.
// Pin-to-LEVEL latency 2+DEBOUNCE cycles; register reads return data one cycle after the read edge.
module gpio_in_debounce #(
    parameter int WIDTH      = 4,
    parameter int DEBOUNCE   = 1000,
    parameter int CNT_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    input  logic             cs,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [7:0]       dout_q, dout_d;
    logic             irq_q;
    logic [7:0]       rdata;
    logic [WIDTH-1:0] din_w;
    logic             wr, rd;

    assign p     = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    assign wr    = cs & we;
    assign rd    = cs & ~we;
    assign din_w = din[WIDTH-1:0];

    generate
        if (WIDTH < 8) begin : g_unused_din
            logic unused_din;
            assign unused_din = ^din[7:WIDTH];
        end
    endgenerate

    // Accept a new level only after DEBOUNCE consecutive differing cycles.
    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (p[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = p[i];
                    rise[i]     = p[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press landing on the same edge as its W1C keeps the bit set.
    always_comb begin
        edge_d   = rise | (edge_q & ~((wr && addr == 2'd1) ? din_w : '0));
        irq_en_d = (wr && addr == 2'd2) ? din_w : irq_en_q;
        rdata    = '0;
        case (addr)
            2'd0:    rdata[WIDTH-1:0] = stable_q;
            2'd1:    rdata[WIDTH-1:0] = edge_q;
            2'd2:    rdata[WIDTH-1:0] = irq_en_q;
            default: rdata[WIDTH-1:0] = p;
        endcase
        dout_d = rd ? rdata : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= IDLE_LVL;
            sync2_q  <= IDLE_LVL;
            stable_q <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            dout_q   <= 8'h00;
            irq_q    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= pins;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            edge_q   <= edge_d;
            irq_en_q <= irq_en_d;
            dout_q   <= dout_d;
            irq_q    <= |(edge_q & irq_en_q);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with DEBOUNCE=8; inputs driven and outputs sampled on negedge.
module tb_gpio_in_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pins;
    logic       cs, we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;
    logic [7:0] v;
    logic       hist [30];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_in_debounce #(
        .WIDTH(4), .DEBOUNCE(8), .CNT_W(4), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .pins(pins), .cs(cs), .we(we),
        .addr(addr), .din(din), .dout(dout), .irq(irq)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        tick();
        cs = 1'b0; we = 1'b0; din = 8'h00;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] r);
        cs = 1'b1; we = 1'b0; addr = a;
        tick();
        r  = dout;
        cs = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pins = 4'hF; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
        repeat (3) tick();
        check_val("rst_dout", dout, 8'h00);
        check_val("rst_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;
        bus_read(2'd0, v); check_val("rst_level", v, 8'h00);
        bus_read(2'd1, v); check_val("rst_edge", v, 8'h00);
        bus_read(2'd2, v); check_val("rst_irqen", v, 8'h00);

        // Clean press on key0 with LEVEL read back every cycle (dout lags LEVEL by one edge).
        bus_write(2'd2, 8'h01);
        pins[0] = 1'b0;
        cs = 1'b1; we = 1'b0; addr = 2'd0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 10) begin
                check_val("press_lvl_e9", dout, 8'h00);
                check_val("press_irq_e10", {7'b0, irq}, 8'h00);
            end
            if (k == 11) begin
                check_val("press_lvl_e10", dout, 8'h01);
                check_val("press_irq_e11", {7'b0, irq}, 8'h01);
            end
        end
        cs = 1'b0;

        bus_read(2'd1, v); check_val("edge_set", v, 8'h01);
        bus_write(2'd1, 8'h00);
        bus_read(2'd1, v); check_val("w1c_zero", v, 8'h01);
        check_val("irq_held", {7'b0, irq}, 8'h01);
        bus_write(2'd1, 8'h01);
        bus_read(2'd1, v); check_val("w1c_clear", v, 8'h00);
        check_val("irq_clear", {7'b0, irq}, 8'h00);

        // Release sets no event.
        pins[0] = 1'b1;
        repeat (12) tick();
        bus_read(2'd0, v); check_val("rel_level", v, 8'h00);
        bus_read(2'd1, v); check_val("rel_edge", v, 8'h00);

        // Bounce on key1: RAW read each cycle reflects pins driven three edges earlier.
        cs = 1'b1; we = 1'b0; addr = 2'd3;
        for (int t = 0; t < 30; t++) begin
            pins[1] = ((t / 3) % 2 == 0) ? 1'b0 : 1'b1;
            hist[t] = ~pins[1];
            tick();
            if (t >= 2) check_val($sformatf("raw_t%0d", t), dout, {6'b0, hist[t-2], 1'b0});
        end
        pins[1] = 1'b1;
        cs = 1'b0;
        repeat (12) tick();
        bus_read(2'd0, v); check_val("bounce_level", v, 8'h00);
        bus_read(2'd1, v); check_val("bounce_edge", v, 8'h00);

        // Key2 accepted on the same edge as its W1C: set wins.
        pins[2] = 1'b0;
        repeat (9) tick();
        bus_write(2'd1, 8'h04);
        bus_read(2'd1, v); check_val("collide_edge", v, 8'h04);
        check_val("masked_irq", {7'b0, irq}, 8'h00);
        bus_read(2'd0, v); check_val("collide_level", v, 8'h04);
        bus_write(2'd1, 8'h04);
        bus_read(2'd1, v); check_val("edge2_clear", v, 8'h00);

        // Read timing and masking of bits above WIDTH.
        cs = 1'b1; we = 1'b0; addr = 2'd0;
        tick();
        check_val("rd_n1", dout, 8'h04);
        cs = 1'b0;
        tick();
        check_val("rd_n2_idle", dout, 8'h00);
        bus_write(2'd2, 8'hFF);
        bus_read(2'd2, v); check_val("irqen_mask", v, 8'h0F);

        // Reset mid-debounce with key2 and key3 held: both re-accepted after release.
        pins[3] = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        repeat (2) tick();
        check_val("rst2_dout", dout, 8'h00);
        check_val("rst2_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;
        cs = 1'b1; we = 1'b0; addr = 2'd0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 10) check_val("rst2_lvl_e9", dout, 8'h00);
            if (k == 11) check_val("rst2_lvl_e10", dout, 8'h0C);
        end
        addr = 2'd1;
        tick();
        check_val("rst2_edge", dout, 8'h0C);
        check_val("rst2_irq_off", {7'b0, irq}, 8'h00);
        cs = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
